// File: rtl/pipe_pipe_stage_reg_placeholder.sv
// Intentionally minimal: companion constants for pipe_stage_reg stats width.
// Latency: none (no logic). Backpressure: not applicable.
package pipe_pipe_stage_reg_placeholder;
  localparam int STALL_CNT_W = 32;
  localparam int FLUSH_CNT_W = 16;
endpackage

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for pipeline boundary registers: occupancy encoding, stage FSM
// states, and per-boundary payload structs whose $bits sets pipe_stage_reg WIDTH.
// No logic; imported by pipe_stage_reg and pipe_skid_slot.
package pipe_stage_reg_pkg;

  typedef logic [1:0] pipe_occ_t;

  localparam pipe_occ_t PIPE_OCC_EMPTY = 2'd0;
  localparam pipe_occ_t PIPE_OCC_ONE   = 2'd1;
  localparam pipe_occ_t PIPE_OCC_FULL  = 2'd2;

  // Encodings match pipe_occ_t so occupancy is the state register itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_dat;
    logic [31:0] rs2_dat;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } idex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] store_dat;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } exmem_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid+data storage slot for pipe_stage_reg; load wins over clear.
// Ports: i_clk, i_rst (sync, active-high), i_load/i_clr controls, i_dat in;
//        o_vld/o_dat registered outputs. Data resets to zero only if RST_DATA!=0.
module pipe_skid_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int RST_DATA = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat
);

  logic             r_vld;
  logic [WIDTH-1:0] r_dat;

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_vld <= 1'b0;
    else if (i_load) r_vld <= 1'b1;
    else if (i_clr)  r_vld <= 1'b0;
  end

  // Without RST_DATA the payload flops carry no reset and come up undefined.
  always_ff @(posedge i_clk) begin
    if (i_rst && (RST_DATA != 0)) r_dat <= '0;
    else if (i_load)              r_dat <= i_dat;
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready, hold (stall) and flush.
// Latency 1 cycle. SKID=1: 2-entry skid, in_ready = registered (state!=FULL) & ~hold;
// SKID=0: single register, in_ready = ~hold & (~valid | out_ready).
// Ports: CLK, RST (sync active-high); in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data downstream; hold, flush; occupancy (0..2).
// Optional macro PIPE_STAGE_REG_STATS_EN adds stall_cycles[31:0], flush_count[15:0].
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int SKID     = 1,
  parameter int RST_DATA = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             hold,
  input  logic             flush,
  output logic [1:0]       occupancy
`ifdef PIPE_STAGE_REG_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      flush_count
`endif
);

  logic             w_in_rdy;
  logic             w_out_vld;
  logic             w_push;
  logic             w_pop;
  logic             w_main_vld;
  logic [WIDTH-1:0] w_main_dat;
  pipe_occ_t        w_occ;

  // hold masks both sides, so no transfer and no state change while stalled.
  assign w_out_vld = w_main_vld & ~hold;
  assign w_push    = in_valid & w_in_rdy;
  assign w_pop     = w_out_vld & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      pipe_state_e      r_state;
      pipe_state_e      w_state_nxt;
      logic             w_main_load, w_main_clr, w_skid_load, w_skid_clr;
      logic             w_skid_vld;
      logic [WIDTH-1:0] w_skid_dat;
      logic [WIDTH-1:0] w_main_src;

      always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_EMPTY;
        else     r_state <= w_state_nxt;
      end

      always_comb begin
        w_state_nxt = r_state;
        w_main_load = 1'b0;
        w_main_clr  = 1'b0;
        w_skid_load = 1'b0;
        w_skid_clr  = 1'b0;
        if (flush) begin
          // Squashes this cycle's push and pop as well as stored beats.
          w_state_nxt = ST_EMPTY;
          w_main_clr  = 1'b1;
          w_skid_clr  = 1'b1;
        end else begin
          case (r_state)
            ST_EMPTY: begin
              if (w_push) begin
                w_state_nxt = ST_ONE;
                w_main_load = 1'b1;
              end
            end
            ST_ONE: begin
              if (w_push && w_pop) begin
                w_main_load = 1'b1;
              end else if (w_push) begin
                w_state_nxt = ST_FULL;
                w_skid_load = 1'b1;
              end else if (w_pop) begin
                w_state_nxt = ST_EMPTY;
                w_main_clr  = 1'b1;
              end
            end
            ST_FULL: begin
              if (w_pop) begin
                w_state_nxt = ST_ONE;
                w_main_load = 1'b1;
                w_skid_clr  = 1'b1;
              end
            end
            default: w_state_nxt = ST_EMPTY;
          endcase
        end
      end

      // An occupied skid entry is always older than the incoming beat.
      assign w_main_src = w_skid_vld ? w_skid_dat : in_data;

      pipe_skid_slot #(.WIDTH(WIDTH), .RST_DATA(RST_DATA)) u_main (
        .i_clk (CLK),
        .i_rst (RST),
        .i_load(w_main_load),
        .i_clr (w_main_clr),
        .i_dat (w_main_src),
        .o_vld (w_main_vld),
        .o_dat (w_main_dat)
      );

      pipe_skid_slot #(.WIDTH(WIDTH), .RST_DATA(RST_DATA)) u_skid (
        .i_clk (CLK),
        .i_rst (RST),
        .i_load(w_skid_load),
        .i_clr (w_skid_clr),
        .i_dat (in_data),
        .o_vld (w_skid_vld),
        .o_dat (w_skid_dat)
      );

      assign w_in_rdy = (r_state != ST_FULL) & ~hold;
      assign w_occ    = pipe_occ_t'(r_state);
    end else begin : g_single
      logic w_load;
      logic w_clr;

      assign w_load = w_push & ~flush;
      assign w_clr  = flush | w_pop;

      pipe_skid_slot #(.WIDTH(WIDTH), .RST_DATA(RST_DATA)) u_main (
        .i_clk (CLK),
        .i_rst (RST),
        .i_load(w_load),
        .i_clr (w_clr),
        .i_dat (in_data),
        .o_vld (w_main_vld),
        .o_dat (w_main_dat)
      );

      assign w_in_rdy = ~hold & (~w_main_vld | out_ready);
      assign w_occ    = w_main_vld ? PIPE_OCC_ONE : PIPE_OCC_EMPTY;
    end
  endgenerate

  assign in_ready  = w_in_rdy;
  assign out_valid = w_out_vld;
  assign out_data  = w_main_dat;
  assign occupancy = w_occ;

`ifdef PIPE_STAGE_REG_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (in_valid && !w_in_rdy && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (flush && (w_occ != PIPE_OCC_EMPTY) && (r_flush_count != '1))
        r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule
